membuf: RTL and testbench

//  In-order load/store buffer between the ALU lanes and the data bus. Accepts up to EXEC_LEN memory ops
//  per cycle, issues them one at a time to the data port, and retires each op with a one-cycle
//  mem_release pulse. Load results go to the multi-port register file (mem_sel/mem_data). That pulse

---
 rtl/membuf_pkg.sv | 44 ++++
 rtl/membuf_mem_align.sv | 41 ++++
 rtl/membuf.sv | 143 ++++++++++++++
 tb/tb_membuf.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/membuf_pkg.sv
// Shared sizing, para-field layout, FSM encoding and queue entry type for membuf.
package membuf_pkg;

   localparam int XLEN     = 32;
   localparam int RGBIT    = 5;
   localparam int EXEC_LEN = 3;
   localparam int MEMB_LEN = 8;
   localparam int MEMB_OFF = 4;                 // clog2(MEMB_LEN+1)
   localparam int PTR_W    = $clog2(MEMB_LEN);

   // mem_para lane layout: {store, unsigned, size[1:0]}
   localparam int PARA_W  = 4;
   localparam int P_STORE = 3;
   localparam int P_UNS   = 2;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   typedef struct packed {
      logic             store;
      logic             uns;
      logic [1:0]       size;
      logic [RGBIT-1:0] rd;
      logic [XLEN-1:0]  addr;
      logic [XLEN-1:0]  wdata;
   } mem_op_t;

   // Circular pointer advance; n never exceeds MEMB_LEN so one wrap is enough.
   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                input logic [MEMB_OFF-1:0] n);
      int s;
      s = int'(p) + int'(n);
      if (s >= MEMB_LEN) s = s - MEMB_LEN;
      return PTR_W'(s);
   endfunction

endpackage

// File: rtl/membuf_mem_align.sv
// Byte-lane steering for the head entry: store byte enables / write shift and
// load byte/halfword extraction with sign or zero extension.
module mem_align
   import membuf_pkg::*;
(
   input  logic [1:0]      size,
   input  logic            uns,
   input  logic [1:0]      ofs,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rdata,
   output logic [3:0]      be,
   output logic [XLEN-1:0] wdata_sh,
   output logic [XLEN-1:0] ldata
);

   logic [XLEN-1:0] rsh;

   // Misaligned H/W simply lose the bits shifted past lane 3.
   always_comb begin
      be = 4'hF;
      case (size)
         SZ_B:    be = 4'b0001 << ofs;
         SZ_H:    be = 4'b0011 << ofs;
         SZ_W:    be = 4'hF;
         default: be = 4'hF;
      endcase
      wdata_sh = wdata << {ofs, 3'b000};
   end

   // Load: bring the addressed byte/half down to bit 0, then extend.
   always_comb begin
      rsh   = rdata >> {ofs, 3'b000};
      ldata = rdata;
      case (size)
         SZ_B:    ldata = {{(XLEN-8){~uns & rsh[7]}}, rsh[7:0]};
         SZ_H:    ldata = {{(XLEN-16){~uns & rsh[15]}}, rsh[15:0]};
         default: ldata = rdata;
      endcase
   end

endmodule

// File: rtl/membuf.sv
// In-order load/store buffer: compacts up to EXEC_LEN ops per cycle into a
// circular queue, issues the head to the data bus and retires one op per cycle.
module membuf
   import membuf_pkg::*;
(
   input  logic                               clk,
   input  logic                               rst,
   input  logic [EXEC_LEN-1:0]                mem_vld,
   input  logic [EXEC_LEN-1:0][PARA_W-1:0]    mem_para,
   input  logic [EXEC_LEN-1:0][RGBIT-1:0]     mem_rd,
   input  logic [EXEC_LEN-1:0][XLEN-1:0]      mem_addr,
   input  logic [EXEC_LEN-1:0][XLEN-1:0]      mem_wdata,
   output logic [MEMB_OFF-1:0]                membuf_cnt,
   output logic [MEMB_OFF-1:0]                membuf_free,
   output logic                               mem_overflow,
   output logic                               dmem_req,
   output logic                               dmem_we,
   output logic [XLEN-1:0]                    dmem_addr,
   output logic [3:0]                         dmem_be,
   output logic [XLEN-1:0]                    dmem_wdata,
   input  logic                               dmem_ready,
   input  logic                               dmem_resp,
   input  logic [XLEN-1:0]                    dmem_rdata,
   output logic                               mem_release,
   output logic [RGBIT-1:0]                   mem_sel,
   output logic [XLEN-1:0]                    mem_data
);

   mem_op_t                          queue [MEMB_LEN];
   mem_op_t [EXEC_LEN-1:0]           lane_op;
   mem_op_t                          hd;
   logic [PTR_W-1:0]                 head, tail;
   logic [MEMB_OFF-1:0]              occ, occ_next, free, n_vld, n_acc;
   logic [EXEC_LEN-1:0][MEMB_OFF-1:0] slot;
   logic [EXEC_LEN-1:0]              acc;
   logic                             remain;
   state_t                           state, state_nxt;
   logic [3:0]                       be;
   logic [XLEN-1:0]                  wsh, ldata;

   for (genvar i = 0; i < EXEC_LEN; i++) begin : g_lane
      assign lane_op[i] = '{store: mem_para[i][P_STORE], uns: mem_para[i][P_UNS],
                            size: mem_para[i][1:0], rd: mem_rd[i],
                            addr: mem_addr[i], wdata: mem_wdata[i]};
   end

   // Free space is from current occupancy: a retire this cycle frees a slot next cycle.
   assign free        = MEMB_OFF'(MEMB_LEN) - occ;
   assign membuf_free = free;
   assign membuf_cnt  = occ - MEMB_OFF'(mem_release);
   assign occ_next    = occ + n_acc - MEMB_OFF'(mem_release);

   // Prefix sum over lane valids: compacted slot per lane, drop lanes past free space.
   always_comb begin
      n_vld = '0;
      n_acc = '0;
      acc   = '0;
      slot  = '0;
      for (int i = 0; i < EXEC_LEN; i++) begin
         slot[i] = n_vld;
         acc[i]  = mem_vld[i] && (n_vld < free);
         n_vld   = n_vld + MEMB_OFF'(mem_vld[i]);
         n_acc   = n_acc + MEMB_OFF'(acc[i]);
      end
      // Entries left after retiring the head, counting this cycle's arrivals.
      remain = (occ + n_acc) > MEMB_OFF'(1);
   end

   assign hd = queue[head];

   mem_align u_align (
      .size     (hd.size),
      .uns      (hd.uns),
      .ofs      (hd.addr[1:0]),
      .wdata    (hd.wdata),
      .rdata    (dmem_rdata),
      .be       (be),
      .wdata_sh (wsh),
      .ldata    (ldata)
   );

   // Issue/retire FSM; bus and retire outputs are decodes of state and bus inputs.
   always_comb begin
      state_nxt   = state;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      dmem_addr   = '0;
      dmem_be     = '0;
      dmem_wdata  = '0;
      mem_release = 1'b0;
      mem_sel     = '0;
      mem_data    = '0;
      case (state)
         ST_IDLE: if (occ != '0) state_nxt = ST_REQ;
         ST_REQ: begin
            dmem_req   = 1'b1;
            dmem_we    = hd.store;
            dmem_addr  = {hd.addr[XLEN-1:2], 2'b00};
            dmem_be    = be;
            dmem_wdata = wsh;
            if (dmem_ready) begin
               if (hd.store) begin
                  mem_release = 1'b1;
                  state_nxt   = remain ? ST_REQ : ST_IDLE;
               end else begin
                  state_nxt   = ST_WAIT;
               end
            end
         end
         ST_WAIT: if (dmem_resp) begin
            mem_release = 1'b1;
            mem_sel     = hd.rd;
            mem_data    = ldata;
            state_nxt   = remain ? ST_REQ : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Control state: FSM, pointers, occupancy and sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         occ          <= '0;
         head         <= '0;
         tail         <= '0;
         mem_overflow <= 1'b0;
      end else begin
         state <= state_nxt;
         occ   <= occ_next;
         tail  <= ptr_add(tail, n_acc);
         if (mem_release)  head <= ptr_add(head, MEMB_OFF'(1));
         if (n_vld > free) mem_overflow <= 1'b1;
      end
   end

   // Entry storage; contents are only meaningful between tail and head, so no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < EXEC_LEN; i++)
         if (!rst && acc[i]) queue[ptr_add(tail, slot[i])] <= lane_op[i];
   end

endmodule

// File: tb/tb_membuf.sv
// Self-checking bench for membuf: directed scenarios plus random traffic, all
// checked against a queue-based reference model of the buffer.
module tb_membuf;
   import membuf_pkg::*;

   logic                            clk = 1'b0;
   logic                            rst;
   logic [EXEC_LEN-1:0]             mem_vld;
   logic [EXEC_LEN-1:0][PARA_W-1:0] mem_para;
   logic [EXEC_LEN-1:0][RGBIT-1:0]  mem_rd;
   logic [EXEC_LEN-1:0][XLEN-1:0]   mem_addr;
   logic [EXEC_LEN-1:0][XLEN-1:0]   mem_wdata;
   logic [MEMB_OFF-1:0]             membuf_cnt, membuf_free;
   logic                            mem_overflow;
   logic                            dmem_req, dmem_we;
   logic [XLEN-1:0]                 dmem_addr, dmem_wdata;
   logic [3:0]                      dmem_be;
   logic                            dmem_ready, dmem_resp;
   logic [XLEN-1:0]                 dmem_rdata;
   logic                            mem_release;
   logic [RGBIT-1:0]                mem_sel;
   logic [XLEN-1:0]                 mem_data;

   always #5 clk = ~clk;

   membuf dut (
      .clk(clk), .rst(rst), .mem_vld(mem_vld), .mem_para(mem_para), .mem_rd(mem_rd),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .membuf_cnt(membuf_cnt),
      .membuf_free(membuf_free), .mem_overflow(mem_overflow), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_ready(dmem_ready), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
      .mem_release(mem_release), .mem_sel(mem_sel), .mem_data(mem_data)
   );

   typedef struct {
      bit        st;
      bit        uns;
      bit [1:0]  sz;
      bit [4:0]  rd;
      bit [31:0] addr;
      bit [31:0] wdata;
   } op_t;

   op_t       lane_op [EXEC_LEN];
   op_t       q [$];               // ops accepted but not yet retired, oldest first
   bit        m_ovf, in_wait;
   int        n_chk, n_fail;
   bit        last_rel;
   bit [4:0]  last_sel;
   bit [31:0] last_data, acc_addr, acc_wdata;
   bit [3:0]  acc_be;
   bit        acc_we;

   function automatic op_t rand_op();
      op_t o;
      o.st    = 1'($urandom_range(0, 1));
      o.uns   = 1'($urandom_range(0, 1));
      o.sz    = 2'($urandom_range(0, 2));
      o.rd    = 5'($urandom_range(0, 31));
      o.addr  = $urandom;
      o.wdata = $urandom;
      return o;
   endfunction

   function automatic bit [3:0] exp_be(op_t o);
      int a = int'(o.addr % 4);
      if (o.sz == 0) return 4'((1 << a) % 16);
      if (o.sz == 1) return 4'((3 << a) % 16);
      return 4'hF;
   endfunction

   function automatic bit [31:0] exp_wdata(op_t o);
      longint unsigned w;
      w = longint'(o.wdata) * (longint'(1) << (8 * (o.addr % 4)));
      return w[31:0];
   endfunction

   function automatic bit [31:0] exp_load(op_t o, bit [31:0] rdata);
      longint v;
      v = longint'(rdata) / (longint'(1) << (8 * (o.addr % 4)));
      if (o.sz == 0) begin
         v = v % 256;
         if (!o.uns && v >= 128) v = v - 256;
      end else if (o.sz == 1) begin
         v = v % 65536;
         if (!o.uns && v >= 32768) v = v - 65536;
      end else begin
         v = longint'(rdata);
      end
      return v[31:0];
   endfunction

   // One clock cycle: drive lanes, check the cycle's outputs against the model, advance.
   task automatic step(input bit [EXEC_LEN-1:0] vld);
      int  occ0, free0, rel_e, nv;
      bit  hd_st;
      op_t h;
      bit [4:0]  e_sel;
      bit [31:0] e_data;
      mem_vld = vld;
      for (int i = 0; i < EXEC_LEN; i++) begin
         mem_para[i]  = {lane_op[i].st, lane_op[i].uns, lane_op[i].sz};
         mem_rd[i]    = lane_op[i].rd;
         mem_addr[i]  = lane_op[i].addr;
         mem_wdata[i] = lane_op[i].wdata;
      end
      #1;
      occ0  = q.size();
      free0 = MEMB_LEN - occ0;
      rel_e = 0;
      hd_st = 1'b0;
      n_chk++;
      if (membuf_free !== 4'(free0)) begin
         n_fail++; $display("FAIL free: got %0d exp %0d", membuf_free, free0);
      end
      if (dmem_req) begin
         n_chk++;
         if (occ0 == 0) begin
            n_fail++; $display("FAIL req_empty: dmem_req=1 with model queue empty");
         end else begin
            h = q[0];
            hd_st = h.st;
            if (dmem_addr !== {h.addr[31:2], 2'b00} || dmem_we !== h.st || dmem_be !== exp_be(h) ||
                (h.st && dmem_wdata !== exp_wdata(h))) begin
               n_fail++;
               $display("FAIL bus: got addr=%h we=%b be=%b wd=%h exp addr=%h we=%b be=%b wd=%h",
                        dmem_addr, dmem_we, dmem_be, dmem_wdata, {h.addr[31:2], 2'b00}, h.st,
                        exp_be(h), exp_wdata(h));
            end
            if (dmem_ready) begin
               acc_addr = dmem_addr; acc_be = dmem_be; acc_wdata = dmem_wdata; acc_we = dmem_we;
               if (h.st) rel_e = 1;
            end
         end
      end
      if (in_wait && dmem_resp && occ0 != 0) rel_e = 1;
      n_chk++;
      if (mem_release !== 1'(rel_e)) begin
         n_fail++; $display("FAIL release: got %b exp %0d", mem_release, rel_e);
      end
      e_sel = '0; e_data = '0;
      if (rel_e != 0) begin
         h = q.pop_front();
         if (!h.st) begin e_sel = h.rd; e_data = exp_load(h, dmem_rdata); end
      end
      n_chk++;
      if (mem_sel !== e_sel || mem_data !== e_data) begin
         n_fail++; $display("FAIL retire_data: got sel=%0d data=%h exp sel=%0d data=%h",
                            mem_sel, mem_data, e_sel, e_data);
      end
      n_chk++;
      if (membuf_cnt !== 4'(occ0 - rel_e)) begin
         n_fail++; $display("FAIL cnt: got %0d exp %0d", membuf_cnt, occ0 - rel_e);
      end
      last_rel = mem_release; last_sel = mem_sel; last_data = mem_data;
      nv = 0;
      for (int i = 0; i < EXEC_LEN; i++)
         if (vld[i]) begin
            if (nv < free0) q.push_back(lane_op[i]);
            nv++;
         end
      if (nv > free0) m_ovf = 1'b1;
      if (dmem_req && dmem_ready && occ0 != 0 && !hd_st) in_wait = 1'b1;
      else if (in_wait && dmem_resp) in_wait = 1'b0;
      @(posedge clk); #1;
      n_chk++;
      if (mem_overflow !== m_ovf) begin
         n_fail++; $display("FAIL overflow: got %b exp %b", mem_overflow, m_ovf);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; mem_vld = '0; dmem_ready = 1'b0; dmem_resp = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      q.delete(); in_wait = 1'b0; m_ovf = 1'b0;
   endtask

   task automatic wait_req(input string tag);
      int c = 0;
      while (!dmem_req && c < 10) begin step('0); c++; end
      n_chk++;
      if (!dmem_req) begin n_fail++; $display("FAIL %s_req_timeout: dmem_req=%b exp 1", tag, dmem_req); end
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++;
      if ({dmem_req, dmem_we, mem_release, mem_overflow} !== 4'b0 || membuf_cnt !== 4'd0 ||
          mem_sel !== 5'd0 || mem_data !== 32'd0 || dmem_addr !== 32'd0 || dmem_be !== 4'd0 ||
          dmem_wdata !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_state: got req=%b cnt=%0d ovf=%b rel=%b sel=%0d data=%h be=%b exp all 0",
                  dmem_req, membuf_cnt, mem_overflow, mem_release, mem_sel, mem_data, dmem_be);
      end
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      lane_op[0] = '{1'b0, 1'b0, 2'd2, 5'd7, 32'h40, 32'h0};
      dmem_ready = 1'b1;
      step(3'b001);
      wait_req("rst_wait");
      step('0);                      // load accepted, DUT now waiting on data
      dmem_ready = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; q.delete(); in_wait = 1'b0;
      n_chk++;
      if (dmem_req !== 1'b0 || membuf_cnt !== 4'd0) begin
         n_fail++; $display("FAIL rst_mid_wait: got req=%b cnt=%0d exp req=0 cnt=0", dmem_req, membuf_cnt);
      end
      dmem_resp = 1'b1; dmem_rdata = 32'hCAFEF00D;
      step('0);
      n_chk++;
      if (last_rel !== 1'b0) begin
         n_fail++; $display("FAIL late_resp: got release=%b exp 0", last_rel);
      end
      dmem_resp = 1'b0;
   endtask

   task automatic test_mixed_lanes();
      int rel = 0;
      do_reset();
      lane_op[0] = '{1'b1, 1'b0, 2'd2, 5'd0, 32'h100, 32'hDEADBEEF};
      lane_op[1] = rand_op();
      lane_op[2] = '{1'b0, 1'b0, 2'd0, 5'd9, 32'h103, 32'h0};
      dmem_ready = 1'b1; dmem_resp = 1'b1; dmem_rdata = 32'h80000000;
      step(3'b101);
      for (int c = 0; c < 20 && rel < 2; c++) begin
         step('0);
         if (last_rel) begin
            rel++;
            n_chk++;
            if (rel == 1 && (acc_be !== 4'hF || last_sel !== 5'd0 || acc_we !== 1'b1 ||
                             acc_wdata !== 32'hDEADBEEF)) begin
               n_fail++; $display("FAIL sw_retire: got be=%b sel=%0d we=%b wd=%h exp be=1111 sel=0 we=1 wd=deadbeef",
                                  acc_be, last_sel, acc_we, acc_wdata);
            end
            if (rel == 2 && (last_data !== 32'hFFFFFF80 || acc_addr !== 32'h100 ||
                             acc_be !== 4'b1000 || last_sel !== 5'd9)) begin
               n_fail++; $display("FAIL lb_retire: got data=%h addr=%h be=%b sel=%0d exp ffffff80 100 1000 9",
                                  last_data, acc_addr, acc_be, last_sel);
            end
         end
      end
      n_chk++;
      if (rel != 2) begin n_fail++; $display("FAIL mixed_timeout: got %0d releases exp 2", rel); end
   endtask

   task automatic test_half_ext();
      int rel = 0;
      do_reset();
      lane_op[0] = '{1'b0, 1'b1, 2'd1, 5'd3, 32'h102, 32'h0};
      lane_op[1] = '{1'b0, 1'b0, 2'd1, 5'd4, 32'h102, 32'h0};
      dmem_ready = 1'b1; dmem_resp = 1'b1; dmem_rdata = 32'h80010000;
      step(3'b011);
      for (int c = 0; c < 20 && rel < 2; c++) begin
         step('0);
         if (last_rel) begin
            rel++;
            n_chk++;
            if (rel == 1 && last_data !== 32'h00008001) begin
               n_fail++; $display("FAIL lhu: got %h exp 00008001", last_data);
            end
            if (rel == 2 && last_data !== 32'hFFFF8001) begin
               n_fail++; $display("FAIL lh: got %h exp ffff8001", last_data);
            end
         end
      end
      n_chk++;
      if (rel != 2) begin n_fail++; $display("FAIL half_timeout: got %0d releases exp 2", rel); end
   endtask

   task automatic test_overflow();
      int rel = 0;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < EXEC_LEN; i++) lane_op[i] = rand_op();
         step(k < 2 ? 3'b111 : 3'b011);
      end
      n_chk++;
      if (membuf_free !== 4'd0 || mem_overflow !== 1'b1 || membuf_cnt !== 4'd8) begin
         n_fail++; $display("FAIL full: got free=%0d ovf=%b cnt=%0d exp free=0 ovf=1 cnt=8",
                            membuf_free, mem_overflow, membuf_cnt);
      end
      dmem_ready = 1'b1; dmem_resp = 1'b1; dmem_rdata = $urandom;
      for (int c = 0; c < 40 && rel < 8; c++) begin
         step('0);
         if (last_rel) rel++;
      end
      n_chk++;
      if (rel != 8 || membuf_cnt !== 4'd0) begin
         n_fail++; $display("FAIL drain: got rel=%0d cnt=%0d exp rel=8 cnt=0", rel, membuf_cnt);
      end
   endtask

   task automatic test_stall();
      do_reset();
      lane_op[0] = '{1'b1, 1'b0, 2'd1, 5'd0, 32'h22, 32'h1234ABCD};
      step(3'b001);
      wait_req("stall");
      for (int c = 0; c < 5; c++) begin
         n_chk++;
         if (dmem_addr !== 32'h20 || dmem_be !== 4'b1100 || dmem_wdata !== 32'hABCD0000 ||
             dmem_we !== 1'b1 || dmem_req !== 1'b1) begin
            n_fail++; $display("FAIL stall_hold: got addr=%h be=%b wd=%h we=%b exp 20 1100 abcd0000 1",
                               dmem_addr, dmem_be, dmem_wdata, dmem_we);
         end
         step('0);
         n_chk++;
         if (last_rel !== 1'b0) begin n_fail++; $display("FAIL stall_rel: got %b exp 0", last_rel); end
      end
      dmem_ready = 1'b1;
      step('0);
      n_chk++;
      if (last_rel !== 1'b1) begin n_fail++; $display("FAIL stall_retire: got %b exp 1", last_rel); end
   endtask

   task automatic test_concurrent_wrap();
      int rel = 0;
      do_reset();
      dmem_ready = 1'b1;
      for (int i = 0; i < EXEC_LEN; i++) begin lane_op[i] = rand_op(); lane_op[i].st = 1'b1; end
      step(3'b111);
      step(3'b011);
      for (int c = 0; c < 20 && q.size() != 0; c++) step('0);
      dmem_ready = 1'b0;
      for (int i = 0; i < EXEC_LEN; i++) lane_op[i] = rand_op();
      lane_op[0].st = 1'b1; lane_op[1].st = 1'b0;
      step(3'b111);
      lane_op[0] = rand_op();
      step(3'b001);
      wait_req("conc");
      for (int i = 0; i < EXEC_LEN; i++) lane_op[i] = rand_op();
      dmem_ready = 1'b1;
      step(3'b111);
      dmem_ready = 1'b0;
      #1;
      n_chk++;
      if (membuf_cnt !== 4'd6) begin n_fail++; $display("FAIL conc_cnt: got %0d exp 6", membuf_cnt); end
      dmem_ready = 1'b1; dmem_resp = 1'b1; dmem_rdata = $urandom;
      for (int c = 0; c < 40 && rel < 6; c++) begin
         step('0);
         if (last_rel) rel++;
      end
      n_chk++;
      if (rel != 6 || membuf_cnt !== 4'd0) begin
         n_fail++; $display("FAIL conc_drain: got rel=%0d cnt=%0d exp rel=6 cnt=0", rel, membuf_cnt);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < EXEC_LEN; i++) lane_op[i] = rand_op();
         dmem_ready = ($urandom_range(0, 3) != 0);
         dmem_resp  = 1'($urandom_range(0, 1));
         dmem_rdata = $urandom;
         step(3'($urandom_range(0, 7)));
      end
      dmem_ready = 1'b1; dmem_resp = 1'b1;
      for (int c = 0; c < 100 && q.size() != 0; c++) step('0);
      n_chk++;
      if (q.size() != 0 || membuf_cnt !== 4'd0) begin
         n_fail++; $display("FAIL random_drain: got left=%0d cnt=%0d exp 0 0", q.size(), membuf_cnt);
      end
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      rst = 1'b1; mem_vld = '0; mem_para = '0; mem_rd = '0; mem_addr = '0; mem_wdata = '0;
      dmem_ready = 1'b0; dmem_resp = 1'b0; dmem_rdata = '0;
      for (int i = 0; i < EXEC_LEN; i++) lane_op[i] = rand_op();
      test_reset();
      test_reset_mid_wait();
      test_mixed_lanes();
      test_half_ext();
      test_overflow();
      test_stall();
      test_concurrent_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
